register_file_mp: RTL

- Parametrised multi-port successor to the core's single-write, dual-read register file.
- Configurable data width, depth, read-port count and write-port count.
- Registered reads with write-first bypass, optional hardwired-zero register, synchronous clear on reset.
- Per-register busy scoreboard for issue-stage hazard detection in dual-issue and out-of-order work.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_bypass_sel.sv | 29 ++
 rtl/register_file_mp.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the multi-port register file
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 1;
    localparam int DEF_ZERO_REG = 1;

    // Replicated to any data width as {DATA_W{ZERO_BIT}}
    localparam logic ZERO_BIT = 1'b0;

    function automatic int addrWidth(input int numRegs);
        return (numRegs <= 2) ? 1 : $clog2(numRegs);
    endfunction

endpackage

// File: rtl/regfile_bypass_sel.sv
// rtl/regfile_bypass_sel.sv - priority match of one read address against all write ports
module regfile_bypass_sel
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic [ADDR_W-1:0]        rdAddr,
    input  logic [NUM_WR-1:0]        wrEn,
    input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
    input  logic [NUM_WR*DATA_W-1:0] wrData,
    output logic                     hit,
    output logic [DATA_W-1:0]        hitData
);

    // Ascending scan so the highest-index matching port is the last to assign
    always_comb begin
        hit     = 1'b0;
        hitData = {DATA_W{ZERO_BIT}};
        for (int j = 0; j < NUM_WR; j++) begin
            if (wrEn[j] && (wrAddr[j*ADDR_W +: ADDR_W] == rdAddr)) begin
                hit     = 1'b1;
                hitData = wrData[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write-first bypass and busy scoreboard
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addrWidth(NUM_REGS),
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic [NUM_RD*ADDR_W-1:0] i_RdAddr,
    output logic [NUM_RD*DATA_W-1:0] o_RdData,
    output logic [NUM_RD-1:0]        o_RdBusy,
    input  logic [NUM_WR-1:0]        i_WrEn,
    input  logic [NUM_WR*ADDR_W-1:0] i_WrAddr,
    input  logic [NUM_WR*DATA_W-1:0] i_WrData,
    input  logic                     i_IssueValid,
    input  logic [ADDR_W-1:0]        i_IssueDest
);

    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0) || (NUM_RD < 1) || (NUM_WR < 1))
    begin : gParamCheck
        $error("register_file_mp: NUM_REGS must be a power of two >= 2 and port counts >= 1");
    end

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busyCleared;
    logic [NUM_REGS-1:0] busyNext;
    logic [NUM_WR-1:0]   wrKeep;

    // Writes to the hardwired-zero register vanish before reaching storage, bypass or scoreboard
    always_comb begin
        wrKeep = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wrKeep[j] = i_WrEn[j] &&
                        !((ZERO_REG != 0) && (i_WrAddr[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    always_comb begin
        busyCleared = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wrKeep[j]) begin
                busyCleared[i_WrAddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        busyNext = busyCleared;
        // A new producer outranks a same-cycle completion of the old one
        if (i_IssueValid && !((ZERO_REG != 0) && (i_IssueDest == '0))) begin
            busyNext[i_IssueDest] = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= {DATA_W{ZERO_BIT}};
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wrKeep[j]) begin
                    regs[i_WrAddr[j*ADDR_W +: ADDR_W]] <= i_WrData[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] rdAddr;
        logic              hit;
        logic [DATA_W-1:0] hitData;
        logic [DATA_W-1:0] dataQ;
        logic              busyQ;

        assign rdAddr = i_RdAddr[k*ADDR_W +: ADDR_W];

        regfile_bypass_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) uBypassSel (
            .rdAddr  (rdAddr),
            .wrEn    (wrKeep),
            .wrAddr  (i_WrAddr),
            .wrData  (i_WrData),
            .hit     (hit),
            .hitData (hitData)
        );

        always_ff @(posedge i_Clock) begin
            if (i_Reset) begin
                dataQ <= {DATA_W{ZERO_BIT}};
                busyQ <= 1'b0;
            end else if (!i_Stall) begin
                if ((ZERO_REG != 0) && (rdAddr == '0)) begin
                    dataQ <= {DATA_W{ZERO_BIT}};
                    busyQ <= 1'b0;
                end else begin
                    dataQ <= hit ? hitData : regs[rdAddr];
                    busyQ <= busyCleared[rdAddr];
                end
            end
        end

        assign o_RdData[k*DATA_W +: DATA_W] = dataQ;
        assign o_RdBusy[k]                  = busyQ;
    end

endmodule
